// File: rtl/baterias_pkg.sv
// Shared types and constants for the dual-battery charge model.
// Holds the FSM state encoding, charge width/limits and saturating helpers.
package baterias_pkg;

  localparam int CW = 4;

  localparam logic [CW-1:0] CARGA_MAX = 4'd15;
  localparam logic [CW-1:0] CARGA_MIN = 4'd0;

  typedef enum logic [2:0] {
    REPOSO      = 3'd0,
    DESCARGA_B1 = 3'd1,
    DESCARGA_B2 = 3'd2,
    SWITCH      = 3'd3,
    CARGA       = 3'd4,
    AGOTADO     = 3'd5
  } estado_t;

  function automatic logic [CW-1:0] sat_inc(
    input logic [CW-1:0] v
  );
    return (v == CARGA_MAX) ? CARGA_MAX : v + 1'b1;
  endfunction

  function automatic logic [CW-1:0] sat_dec(
    input logic [CW-1:0] v
  );
    return (v == CARGA_MIN) ? CARGA_MIN : v - 1'b1;
  endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and flags the last count.
// Ports: clk, rst_n (sync, active-low), tick (high when cnt == TICK_DIV-1).
module prescaler_tick #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/modelo_carga_baterias.sv
// Dual-battery charge model: discharge under load, switchover, charging.
// Ports: clk, rst_n, cargador_on, consumo_on -> two charge levels,
// bateria_activa, estado, lleno, agotado, paso (step-valid pulse).
module modelo_carga_baterias
  import baterias_pkg::*;
#(
  parameter int TICK_DIV      = 4,
  parameter int CARGA_INICIAL = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cargador_on,
  input  logic          consumo_on,
  output logic [CW-1:0] carga_bateria1,
  output logic [CW-1:0] carga_bateria2,
  output logic          bateria_activa,
  output logic [2:0]    estado,
  output logic          lleno,
  output logic          agotado,
  output logic          paso
);

  localparam logic [CW-1:0] C_INI = CW'(CARGA_INICIAL);

  logic          tick;
  estado_t       st, st_n;
  logic [CW-1:0] c1, c1_n;
  logic [CW-1:0] c2, c2_n;
  logic          act, act_n;
  logic [CW-1:0] c_act;

  prescaler_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_pre (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st   <= REPOSO;
      c1   <= C_INI;
      c2   <= C_INI;
      act  <= 1'b0;
      paso <= 1'b0;
    end else begin
      st   <= st_n;
      c1   <= c1_n;
      c2   <= c2_n;
      act  <= act_n;
      paso <= tick;
    end
  end

  assign c_act = act ? c2 : c1;

  always_comb begin
    st_n  = st;
    c1_n  = c1;
    c2_n  = c2;
    act_n = act;
    if (tick) begin
      if (cargador_on) begin
        st_n = CARGA;
        // Lower battery charges first; bat1 wins a tie.
        if (c1 <= c2)
          c1_n = sat_inc(c1);
        else
          c2_n = sat_inc(c2);
      end else if (st == AGOTADO) begin
        st_n = AGOTADO;
      end else if (consumo_on) begin
        if (c1 == CARGA_MIN && c2 == CARGA_MIN) begin
          st_n = AGOTADO;
        end else if (c_act != CARGA_MIN) begin
          if (act) begin
            st_n = DESCARGA_B2;
            c2_n = sat_dec(c2);
          end else begin
            st_n = DESCARGA_B1;
            c1_n = sat_dec(c1);
          end
        end else begin
          // Active is empty, other is not: swap, no drain this step.
          st_n  = SWITCH;
          act_n = ~act;
        end
      end else begin
        st_n = REPOSO;
      end
    end
  end

  always_comb begin
    carga_bateria1 = c1;
    carga_bateria2 = c2;
    bateria_activa = act;
    estado         = st;
    lleno   = (c1 == CARGA_MAX) && (c2 == CARGA_MAX);
    agotado = (c1 == CARGA_MIN) && (c2 == CARGA_MIN);
  end

endmodule

// File: tb/tb_modelo_carga_baterias.sv
// Directed self-checking bench for modelo_carga_baterias (TICK_DIV=4).
// Walks reset, idle, discharge, switchover, empty, charge and reset cases.
module tb_modelo_carga_baterias;
  import baterias_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cargador_on = 1'b0;
  logic       consumo_on = 1'b0;
  logic [3:0] carga_bateria1;
  logic [3:0] carga_bateria2;
  logic       bateria_activa;
  logic [2:0] estado;
  logic       lleno;
  logic       agotado;
  logic       paso;

  int n_cmp = 0;
  int n_bad = 0;
  int e1, e2;

  modelo_carga_baterias #(
    .TICK_DIV     (4),
    .CARGA_INICIAL(15)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cargador_on   (cargador_on),
    .consumo_on    (consumo_on),
    .carga_bateria1(carga_bateria1),
    .carga_bateria2(carga_bateria2),
    .bateria_activa(bateria_activa),
    .estado        (estado),
    .lleno         (lleno),
    .agotado       (agotado),
    .paso          (paso)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all(
    input string tag,
    input int    b1,
    input int    b2,
    input int    act,
    input int    st
  );
    chk({tag, ".bat1"}, 32'(carga_bateria1), b1);
    chk({tag, ".bat2"}, 32'(carga_bateria2), b2);
    chk({tag, ".act"}, 32'(bateria_activa), act);
    chk({tag, ".estado"}, 32'(estado), st);
    chk({tag, ".lleno"}, 32'(lleno),
        (b1 == 15 && b2 == 15) ? 1 : 0);
    chk({tag, ".agotado"}, 32'(agotado),
        (b1 == 0 && b2 == 0) ? 1 : 0);
  endtask

  // Apply inputs for one full prescaler period, land just after the tick.
  task automatic step(input logic c, input logic l);
    cargador_on = c;
    consumo_on  = l;
    repeat (4) @(posedge clk);
    #1;
    chk("paso_step", 32'(paso), 1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 15, 15, 0, REPOSO);
    chk("reset.paso", 32'(paso), 0);
    chk("reset.cnt", 32'(dut.u_pre.cnt), 0);
    rst_n = 1'b1;

    // Idle: paso only at cycles 4, 8, 12
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle_paso%0d", cyc), 32'(paso),
          (cyc % 4 == 0) ? 1 : 0);
    end
    chk_all("idle", 15, 15, 0, REPOSO);

    // Discharge bat1 to 3, then reset mid-count
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1);
      chk_all($sformatf("dis1_%0d", i),
              15 - i, 15, 0, DESCARGA_B1);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_all("midrst", 15, 15, 0, REPOSO);
    chk("midrst.paso", 32'(paso), 0);
    chk("midrst.cnt", 32'(dut.u_pre.cnt), 0);
    rst_n = 1'b1;

    // Full discharge of bat1
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, 1'b1);
      chk_all($sformatf("drain1_%0d", i),
              15 - i, 15, 0, DESCARGA_B1);
    end
    step(1'b0, 1'b1);
    chk_all("switch1", 0, 15, 1, SWITCH);
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, 1'b1);
      chk_all($sformatf("drain2_%0d", i),
              0, 15 - i, 1, DESCARGA_B2);
    end
    step(1'b0, 1'b1);
    chk_all("empty", 0, 0, 1, AGOTADO);
    step(1'b0, 1'b1);
    chk_all("empty_load", 0, 0, 1, AGOTADO);
    step(1'b0, 1'b0);
    chk_all("empty_idle", 0, 0, 1, AGOTADO);

    // Recover by charging, alternating batteries
    step(1'b1, 1'b0);
    chk_all("chg_a", 1, 0, 1, CARGA);
    step(1'b1, 1'b1);
    chk_all("chg_b", 1, 1, 1, CARGA);
    step(1'b0, 1'b1);
    chk_all("dis_b2", 1, 0, 1, DESCARGA_B2);
    step(1'b0, 1'b1);
    chk_all("switch0", 1, 0, 0, SWITCH);

    // Charge up to (9,9)
    e1 = 1;
    e2 = 0;
    for (int i = 1; i <= 17; i++) begin
      step(1'b1, 1'b0);
      if (e1 <= e2) e1++;
      else e2++;
      chk_all($sformatf("chg_%0d", i), e1, e2, 0, CARGA);
    end
    chk_all("at99", 9, 9, 0, CARGA);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk_all("at79", 7, 9, 0, DESCARGA_B1);

    // Charger beats load; tie at (9,9) goes to bat1
    step(1'b1, 1'b1);
    chk_all("c79_1", 8, 9, 0, CARGA);
    step(1'b1, 1'b1);
    chk_all("c79_2", 9, 9, 0, CARGA);
    step(1'b1, 1'b1);
    chk_all("c79_3", 10, 9, 0, CARGA);
    step(1'b1, 1'b1);
    chk_all("c79_4", 10, 10, 0, CARGA);
    e1 = 10;
    e2 = 10;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1);
      if (e1 <= e2) e1++;
      else e2++;
      chk_all($sformatf("cfull_%0d", i), e1, e2, 0, CARGA);
    end
    chk_all("full", 15, 15, 0, CARGA);
    step(1'b1, 1'b0);
    chk_all("full_sat", 15, 15, 0, CARGA);

    // Load toggled only on non-tick cycles is ignored
    cargador_on = 1'b0;
    for (int k = 0; k < 4; k++) begin
      consumo_on = (k != 3);
      @(posedge clk);
      #1;
    end
    chk("tog.paso", 32'(paso), 1);
    chk_all("toggle", 15, 15, 0, REPOSO);
    consumo_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
